// File: rtl/gpr_dbg_arb_if.sv
// Debug request/response channel between a debug agent and the GPR debug arbiter.
// Signal names keep the arbiter's port naming so both sides read the same.
interface gpr_dbg_arb_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          dbg_req_valid_i;
    logic          dbg_req_ready_o;
    logic          dbg_req_we_i;
    logic [AW-1:0] dbg_req_addr_i;
    logic [DW-1:0] dbg_req_wdata_i;
    logic          dbg_rsp_valid_o;
    logic          dbg_rsp_ready_i;
    logic [DW-1:0] dbg_rsp_rdata_o;

    modport slave (
        input  dbg_req_valid_i,
        output dbg_req_ready_o,
        input  dbg_req_we_i,
        input  dbg_req_addr_i,
        input  dbg_req_wdata_i,
        output dbg_rsp_valid_o,
        input  dbg_rsp_ready_i,
        output dbg_rsp_rdata_o
    );

    modport master (
        output dbg_req_valid_i,
        input  dbg_req_ready_o,
        output dbg_req_we_i,
        output dbg_req_addr_i,
        output dbg_req_wdata_i,
        input  dbg_rsp_valid_o,
        output dbg_rsp_ready_i,
        input  dbg_rsp_rdata_o
    );
endinterface

// File: rtl/gpr_dbg_arb.sv
// Arbitrates debug GPR reads/writes against core writeback; the core always wins,
// and a debug write starved for STARVE_LIMIT cycles stalls the core until it lands.
module gpr_dbg_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    gpr_dbg_arb_if.slave        dbg,
    input  logic                core_wen_i,
    input  logic [4:0]          core_waddr_i,
    input  logic [31:0]         core_wdata_i,
    output logic                core_stall_o,
    output logic                rf_wen_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic [4:0]          rf_raddr_o,
    input  logic [31:0]         rf_rdata_i
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ready_c;
    logic          dbg_wen_c;
    logic          addr_zero_c;
    logic          contended_c;

    assign addr_zero_c = (addr_q == '0);
    // Only a real (non-x0) write can collide with core writeback.
    assign contended_c = we_q && !addr_zero_c && core_wen_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ready_c   = 1'b0;
        dbg_wen_c = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (dbg.dbg_req_valid_i) begin
                    we_d    = dbg.dbg_req_we_i;
                    addr_d  = dbg.dbg_req_addr_i;
                    wdata_d = dbg.dbg_req_wdata_i;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (contended_c) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    dbg_wen_c = we_q && !addr_zero_c;
                    cnt_d     = '0;
                    state_d   = RESP;
                    // Read data: x0 reads zero, then bypass same-cycle core writeback.
                    if (we_q || addr_zero_c) begin
                        rdata_d = '0;
                    end else if (core_wen_i && (core_waddr_i == addr_q)) begin
                        rdata_d = core_wdata_i;
                    end else begin
                        rdata_d = rf_rdata_i;
                    end
                end
            end
            RESP: begin
                if (dbg.dbg_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        stall_d = (state_q == PEND) && (state_d == PEND) && (cnt_q >= CW'(STARVE_LIMIT));
    end

    assign dbg.dbg_req_ready_o = ready_c && !rst_i;
    assign dbg.dbg_rsp_valid_o = (state_q == RESP) && !rst_i;
    assign dbg.dbg_rsp_rdata_o = rdata_q;
    assign core_stall_o        = stall_q;

    // Core writeback passes straight through; the debug write only fills idle slots.
    always_comb begin
        rf_wen_o   = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (core_wen_i) begin
            rf_wen_o   = 1'b1;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end else if (dbg_wen_c && !rst_i) begin
            rf_wen_o   = 1'b1;
            rf_waddr_o = addr_q;
            rf_wdata_o = wdata_q;
        end
    end

    assign rf_raddr_o = (state_q == PEND) ? addr_q : '0;

endmodule
